// File: rtl/mips_ctrl_alu.sv
// ============================================================================
// Module   : mips_ctrl_alu
// Brief    : Single-cycle MIPS main decode, ALU control and 32-bit ALU,
//            with every output registered on one edge. Optional NOR via
//            macro ALU_NOR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_alu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              reg_dst_o,
  output logic              branch_o,
  output logic              mem_read_o,
  output logic              mem_to_reg_o,
  output logic              mem_write_o,
  output logic              alu_src_o,
  output logic              reg_write_o,
  output logic              jump_o,
  output logic [1:0]        alu_op_o,
  output logic [3:0]        alu_ctl_o,
  output logic [DATA_W-1:0] alu_out_o,
  output logic              zero_o
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;
  localparam logic [5:0] FN_NOR = 6'd39;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  // Strobe vector order: reg_dst, branch, mem_read, mem_to_reg,
  // mem_write, alu_src, reg_write, jump
  logic [7:0]        strobes_d, strobes_q;
  logic [1:0]        alu_op_d,  alu_op_q;
  logic [3:0]        alu_ctl_d, alu_ctl_q;
  logic [DATA_W-1:0] alu_out_d, alu_out_q;
  logic              zero_q;

  always_comb begin
    strobes_d = 8'b0000_0000;
    alu_op_d  = 2'b00;
    case (opcode_i)
      OP_RTYPE: begin strobes_d = 8'b1000_0010; alu_op_d = 2'b10; end
      OP_LW:    strobes_d = 8'b0011_0110;
      OP_SW:    strobes_d = 8'b0000_1100;
      OP_BEQ:   begin strobes_d = 8'b0100_0000; alu_op_d = 2'b01; end
      OP_ADDI:  strobes_d = 8'b0000_0110;
      OP_J:     strobes_d = 8'b0000_0001;
      default:  ;
    endcase
  end

  always_comb begin
    alu_ctl_d = CTL_BAD;
    case (alu_op_d)
      2'b00: alu_ctl_d = CTL_ADD;
      2'b01: alu_ctl_d = CTL_SUB;
      2'b10: begin
        case (funct_i)
          FN_ADD:  alu_ctl_d = CTL_ADD;
          FN_SUB:  alu_ctl_d = CTL_SUB;
          FN_AND:  alu_ctl_d = CTL_AND;
          FN_OR:   alu_ctl_d = CTL_OR;
          FN_SLT:  alu_ctl_d = CTL_SLT;
`ifdef ALU_NOR_EN
          FN_NOR:  alu_ctl_d = CTL_NOR;
`endif
          default: alu_ctl_d = CTL_BAD;
        endcase
      end
      default: alu_ctl_d = CTL_BAD;
    endcase
  end

  always_comb begin
    alu_out_d = '0;
    case (alu_ctl_d)
      CTL_AND: alu_out_d = a_i & b_i;
      CTL_OR:  alu_out_d = a_i | b_i;
      CTL_ADD: alu_out_d = a_i + b_i;
      CTL_SUB: alu_out_d = a_i - b_i;
      // True signed compare so overflowing operand pairs still order correctly
      CTL_SLT: alu_out_d = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_NOR_EN
      CTL_NOR: alu_out_d = ~(a_i | b_i);
`endif
      default: alu_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobes_q <= 8'b0000_0000;
      alu_op_q  <= 2'b00;
      alu_ctl_q <= 4'b0000;
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      strobes_q <= strobes_d;
      alu_op_q  <= alu_op_d;
      alu_ctl_q <= alu_ctl_d;
      alu_out_q <= alu_out_d;
      zero_q    <= (alu_out_d == '0);
    end
  end

  assign reg_dst_o    = strobes_q[7];
  assign branch_o     = strobes_q[6];
  assign mem_read_o   = strobes_q[5];
  assign mem_to_reg_o = strobes_q[4];
  assign mem_write_o  = strobes_q[3];
  assign alu_src_o    = strobes_q[2];
  assign reg_write_o  = strobes_q[1];
  assign jump_o       = strobes_q[0];
  assign alu_op_o     = alu_op_q;
  assign alu_ctl_o    = alu_ctl_q;
  assign alu_out_o    = alu_out_q;
  assign zero_o       = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_ctrl_alu.sv
// ============================================================================
// Module   : tb_mips_ctrl_alu
// Brief    : Scoreboard bench for mips_ctrl_alu (directed + random stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_ctrl_alu;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        opcode_i, funct_i;
  logic [DATA_W-1:0] a_i, b_i;
  logic reg_dst_o, branch_o, mem_read_o, mem_to_reg_o;
  logic mem_write_o, alu_src_o, reg_write_o, jump_o;
  logic [1:0]        alu_op_o;
  logic [3:0]        alu_ctl_o;
  logic [DATA_W-1:0] alu_out_o;
  logic              zero_o;

  typedef struct packed {
    logic              reg_dst, branch, mem_read, mem_to_reg;
    logic              mem_write, alu_src, reg_write, jump;
    logic [1:0]        alu_op;
    logic [3:0]        alu_ctl;
    logic [DATA_W-1:0] alu_out;
    logic              zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mips_ctrl_alu #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .funct_i(funct_i),
    .a_i(a_i), .b_i(b_i),
    .reg_dst_o(reg_dst_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_write_o(mem_write_o),
    .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .jump_o(jump_o),
    .alu_op_o(alu_op_o), .alu_ctl_o(alu_ctl_o), .alu_out_o(alu_out_o),
    .zero_o(zero_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t e;
    e = '0;
    if (r) begin
      e.zero = 1'b1;
      return e;
    end
    if (op == 6'd0)       begin e.reg_dst = 1; e.reg_write = 1; e.alu_op = 2'b10; end
    else if (op == 6'd35) begin e.alu_src = 1; e.mem_to_reg = 1; e.reg_write = 1; e.mem_read = 1; end
    else if (op == 6'd43) begin e.alu_src = 1; e.mem_write = 1; end
    else if (op == 6'd4)  begin e.branch = 1; e.alu_op = 2'b01; end
    else if (op == 6'd8)  begin e.alu_src = 1; e.reg_write = 1; end
    else if (op == 6'd2)  e.jump = 1;

    if (e.alu_op == 2'b00)      e.alu_ctl = 4'b0010;
    else if (e.alu_op == 2'b01) e.alu_ctl = 4'b0110;
    else begin
      case (fn)
        6'd32:   e.alu_ctl = 4'b0010;
        6'd34:   e.alu_ctl = 4'b0110;
        6'd36:   e.alu_ctl = 4'b0000;
        6'd37:   e.alu_ctl = 4'b0001;
        6'd42:   e.alu_ctl = 4'b0111;
`ifdef ALU_NOR_EN
        6'd39:   e.alu_ctl = 4'b1100;
`endif
        default: e.alu_ctl = 4'b1111;
      endcase
    end

    case (e.alu_ctl)
      4'b0000: e.alu_out = a & b;
      4'b0001: e.alu_out = a | b;
      4'b0010: e.alu_out = a + b;
      4'b0110: e.alu_out = a - b;
      4'b0111: begin
        // Independent signed ordering: differing signs decide, else unsigned compare
        if (a[DATA_W-1] != b[DATA_W-1]) e.alu_out = {31'd0, a[DATA_W-1]};
        else                            e.alu_out = {31'd0, (a < b)};
      end
`ifdef ALU_NOR_EN
      4'b1100: e.alu_out = ~(a | b);
`endif
      default: e.alu_out = '0;
    endcase
    e.zero = (e.alu_out == '0);
    return e;
  endfunction

  // Drive one sample, push its expectation, compare after the capturing edge
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t e;
    @(negedge clk);
    rst = r; opcode_i = op; funct_i = fn; a_i = a; b_i = b;
    exp_q.push_back(model(r, op, fn, a, b));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("strobes", {reg_dst_o, branch_o, mem_read_o, mem_to_reg_o,
                        mem_write_o, alu_src_o, reg_write_o, jump_o},
            {e.reg_dst, e.branch, e.mem_read, e.mem_to_reg,
             e.mem_write, e.alu_src, e.reg_write, e.jump});
      check("alu_op",  alu_op_o,  e.alu_op);
      check("alu_ctl", alu_ctl_o, e.alu_ctl);
      check("alu_out", alu_out_o, e.alu_out);
      check("zero",    zero_o,    e.zero);
    end
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [8];
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2, 6'd63, 6'd17};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0, 6'd13};
    rst = 1'b1; opcode_i = '0; funct_i = '0; a_i = '0; b_i = '0;

    step(1'b1, 6'($urandom), 6'($urandom), $urandom, $urandom);
    step(1'b1, 6'd0, 6'd32, 32'h5, 32'h7);
    check("rst_zero", zero_o, 1'b1);
    check("rst_out", alu_out_o, 32'h0);

    step(1'b0, 6'd0, 6'd32, 32'hFFFF_FFFF, 32'h1);
    check("radd_out", alu_out_o, 32'h0);
    check("radd_zero", zero_o, 1'b1);
    step(1'b0, 6'd0, 6'd34, 32'h5, 32'h7);
    check("rsub_out", alu_out_o, 32'hFFFF_FFFE);
    step(1'b0, 6'd35, 6'd0, 32'h100, 32'h8);
    check("lw_out", alu_out_o, 32'h108);
    step(1'b0, 6'd43, 6'd0, 32'h100, 32'h8);
    check("sw_regwr", reg_write_o, 1'b0);
    step(1'b0, 6'd4, 6'd0, 32'h1234, 32'h1234);
    check("beq_zero", zero_o, 1'b1);
    step(1'b0, 6'd4, 6'd0, 32'h1235, 32'h1234);
    check("bne_zero", zero_o, 1'b0);
    step(1'b0, 6'd0, 6'd36, 32'hF0F0, 32'hFF00);
    check("and_out", alu_out_o, 32'hF000);
    step(1'b0, 6'd0, 6'd37, 32'hF0F0, 32'hFF00);
    check("or_out", alu_out_o, 32'hFFF0);
    step(1'b0, 6'd0, 6'd42, 32'h8000_0000, 32'h1);
    check("slt_neg", alu_out_o, 32'h1);
    step(1'b0, 6'd0, 6'd42, 32'h7FFF_FFFF, 32'h8000_0000);
    check("slt_ovf", alu_out_o, 32'h0);
    step(1'b0, 6'd0, 6'd39, 32'h0, 32'h0);
`ifdef ALU_NOR_EN
    check("nor_out", alu_out_o, 32'hFFFF_FFFF);
`else
    check("nor_off_out", alu_out_o, 32'h0);
    check("nor_off_ctl", alu_ctl_o, 4'b1111);
`endif
    step(1'b0, 6'd2, 6'd0, 32'h3, 32'h4);
    check("j_jump", jump_o, 1'b1);
    step(1'b0, 6'd63, 6'd0, 32'h3, 32'h4);
    check("ill_out", alu_out_o, 32'h7);
    step(1'b0, 6'd8, 6'd0, 32'hFFFF_FFF0, 32'h10);
    check("addi_wrap", alu_out_o, 32'h0);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 7) == 0), ops[$urandom_range(0, 7)],
           fns[$urandom_range(0, 7)], $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
